// File: rtl/key_sched_ctrl_pkg.sv
// Shared DES key-schedule definitions: widths, permutation tables,
// shift schedule, controller states and small bit-manipulation helpers.
package key_sched_ctrl_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Entry j is the DES key bit number feeding PC1 output bit j+1.
  localparam int PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Entry j is the C||D bit number feeding subkey bit j+1.
  localparam int PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Entry i-1 holds s[i], the left-rotation applied before round i.
  localparam int SHIFT_TAB [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // DES bit n lives at vector index (width - n): bit 1 is the MSB.
  function automatic logic [CD_W-1:0] pc1_f(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int j = 0; j < CD_W; j++) begin
      r[6'(CD_W-1-j)] = key[6'(KEY_W-PC1_TAB[j])];
    end
    return r;
  endfunction

  function automatic logic [1:0] shift_f(input logic [3:0] idx);
    return 2'(SHIFT_TAB[idx]);
  endfunction

  function automatic logic [HALF_W-1:0] rotl28_f(input logic [HALF_W-1:0] h, input logic [1:0] n);
    return (n == 2'd1) ? {h[HALF_W-2:0], h[HALF_W-1]} : {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28_f(input logic [HALF_W-1:0] h, input logic [1:0] n);
    return (n == 2'd1) ? {h[0], h[HALF_W-1:1]} : {h[1:0], h[HALF_W-1:2]};
  endfunction

  // C and D rotate independently.
  function automatic logic [CD_W-1:0] rotl_cd_f(input logic [CD_W-1:0] cd, input logic [1:0] n);
    return {rotl28_f(cd[CD_W-1:HALF_W], n), rotl28_f(cd[HALF_W-1:0], n)};
  endfunction

  function automatic logic [CD_W-1:0] rotr_cd_f(input logic [CD_W-1:0] cd, input logic [1:0] n);
    return {rotr28_f(cd[CD_W-1:HALF_W], n), rotr28_f(cd[HALF_W-1:0], n)};
  endfunction

endpackage

// File: rtl/key_sched_ctrl_pc2_perm.sv
// PC2 compression permutation: 56-bit C||D to 48-bit round subkey.
module pc2_perm
  import key_sched_ctrl_pkg::*;
(
  input  logic [CD_W-1:0]     cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  // Pure bit selection, no logic.
  always_comb begin
    subkey_o = '0;
    for (int j = 0; j < SUBKEY_W; j++) begin
      subkey_o[6'(SUBKEY_W-1-j)] = cd_i[6'(CD_W-PC2_TAB[j])];
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// DES / 3DES-EDE round-subkey sequencer with a valid/ready output stream.
// C,D are kept already positioned for the presented subkey so SUBKEY is a
// pure permutation of registers and holds naturally during stalls.
module key_sched_ctrl
  import key_sched_ctrl_pkg::*;
#(
  parameter int TRIPLE = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                decrypt_i,
  input  logic [KEY_W-1:0]    key_a_i,
  input  logic [KEY_W-1:0]    key_b_i,
  input  logic [KEY_W-1:0]    key_c_i,
  output logic [SUBKEY_W-1:0] subkey_o,
  output logic                subkey_valid_o,
  input  logic                subkey_ready_i,
  output logic [3:0]          round_o,
  output logic [1:0]          pass_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [1:0] LAST_PASS = (TRIPLE != 0) ? 2'd2 : 2'd0;

  state_e            state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [3:0]        round_q, round_d;
  logic [1:0]        pass_q, pass_d;
  logic              dec_q, dec_d;
  logic [KEY_W-1:0]  ka_q, ka_d, kb_q, kb_d, kc_q, kc_d;

  logic              run, xfer, cur_dir, end_of_pass, last;
  logic              nxt_dir;

  // EDE: the middle pass runs opposite to the requested direction.
  function automatic logic dir_f(input logic dec, input logic [1:0] p);
    return dec ^ ((TRIPLE != 0) && (p == 2'd1));
  endfunction

  // Decryption walks the key bundle backwards (C, B, A).
  function automatic logic [KEY_W-1:0] key_f(input logic dec, input logic [1:0] p,
                                             input logic [KEY_W-1:0] a,
                                             input logic [KEY_W-1:0] b,
                                             input logic [KEY_W-1:0] c);
    if (TRIPLE == 0) return a;
    case (p)
      2'd0:    return dec ? c : a;
      2'd1:    return b;
      default: return dec ? a : c;
    endcase
  endfunction

  // Encrypt starts at C1,D1 (K1); decrypt at C16,D16 which equals PC1 (K16).
  function automatic logic [CD_W-1:0] load_f(input logic [KEY_W-1:0] key, input logic dir);
    return dir ? pc1_f(key) : rotl_cd_f(pc1_f(key), 2'd1);
  endfunction

  assign run         = (state_q == ST_RUN);
  assign xfer        = run & subkey_ready_i;
  assign cur_dir     = dir_f(dec_q, pass_q);
  assign end_of_pass = cur_dir ? (round_q == 4'd0) : (round_q == 4'd15);
  assign last        = run & end_of_pass & (pass_q == LAST_PASS);
  assign nxt_dir     = dir_f(dec_q, 2'(pass_q + 2'd1));

  // Next-state: FSM, pass/round counters and C,D stepping.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    pass_d  = pass_q;
    dec_d   = dec_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    kc_d    = kc_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_RUN;
          dec_d   = decrypt_i;
          ka_d    = key_a_i;
          kb_d    = key_b_i;
          kc_d    = key_c_i;
          pass_d  = 2'd0;
          cd_d    = load_f(key_f(decrypt_i, 2'd0, key_a_i, key_b_i, key_c_i),
                           dir_f(decrypt_i, 2'd0));
          round_d = dir_f(decrypt_i, 2'd0) ? 4'd15 : 4'd0;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (last) begin
            state_d = ST_FIN;
          end else if (end_of_pass) begin
            pass_d  = 2'(pass_q + 2'd1);
            cd_d    = load_f(key_f(dec_q, 2'(pass_q + 2'd1), ka_q, kb_q, kc_q), nxt_dir);
            round_d = nxt_dir ? 4'd15 : 4'd0;
          end else if (cur_dir) begin
            cd_d    = rotr_cd_f(cd_q, shift_f(round_q));
            round_d = round_q - 4'd1;
          end else begin
            cd_d    = rotl_cd_f(cd_q, shift_f(round_q + 4'd1));
            round_d = round_q + 4'd1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including keys.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= '0;
      pass_q  <= '0;
      dec_q   <= 1'b0;
      ka_q    <= '0;
      kb_q    <= '0;
      kc_q    <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      pass_q  <= pass_d;
      dec_q   <= dec_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      kc_q    <= kc_d;
    end
  end

  pc2_perm u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (subkey_o)
  );

  assign subkey_valid_o = run;
  assign round_o        = round_q;
  assign pass_o         = pass_q;
  assign last_o         = last;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_FIN);

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Randomized bench for key_sched_ctrl (single and triple instances) against
// a reference that computes each subkey directly from the DES definition.
module tb_key_sched_ctrl;

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_REF  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_REF = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] sk;
    int          rnd;
    int          pas;
    bit          lst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, decrypt, ready, sel;
  logic [63:0] key_a, key_b, key_c;

  logic [47:0] subkey_s, subkey_t, subkey;
  logic        valid_s, valid_t, valid;
  logic [3:0]  round_s, round_t, round;
  logic [1:0]  pass_s, pass_t, pass_w;
  logic        last_s, last_t, last;
  logic        busy_s, busy_t, busy;
  logic        done_s, done_t, done;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [47:0] first_sk, last_sk;
  int          first_rnd, last_rnd;

  always #5 clk = ~clk;

  key_sched_ctrl #(.TRIPLE(0)) u_single (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .abort_i(abort), .decrypt_i(decrypt),
    .key_a_i(key_a), .key_b_i(key_b), .key_c_i(key_c),
    .subkey_o(subkey_s), .subkey_valid_o(valid_s), .subkey_ready_i(ready),
    .round_o(round_s), .pass_o(pass_s), .last_o(last_s), .busy_o(busy_s), .done_o(done_s));

  key_sched_ctrl #(.TRIPLE(1)) u_triple (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .abort_i(abort), .decrypt_i(decrypt),
    .key_a_i(key_a), .key_b_i(key_b), .key_c_i(key_c),
    .subkey_o(subkey_t), .subkey_valid_o(valid_t), .subkey_ready_i(ready),
    .round_o(round_t), .pass_o(pass_t), .last_o(last_t), .busy_o(busy_t), .done_o(done_t));

  assign subkey = sel ? subkey_t : subkey_s;
  assign valid  = sel ? valid_t  : valid_s;
  assign round  = sel ? round_t  : round_s;
  assign pass_w = sel ? pass_t   : pass_s;
  assign last   = sel ? last_t   : last_s;
  assign busy   = sel ? busy_t   : busy_s;
  assign done   = sel ? done_t   : done_s;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Ki from the textbook definition: PC1, cumulative left rotation, PC2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    bit c0[28], d0[28], cd[56];
    int tot;
    logic [47:0] k;
    tot = 0;
    for (int i = 0; i < n; i++) tot += SH[i];
    for (int j = 0; j < 28; j++) begin
      c0[j] = key[64-PC1[j]];
      d0[j] = key[64-PC1[28+j]];
    end
    for (int j = 0; j < 28; j++) begin
      cd[j]    = c0[(j+tot)%28];
      cd[28+j] = d0[(j+tot)%28];
    end
    for (int j = 0; j < 48; j++) k[47-j] = cd[PC2[j]-1];
    return k;
  endfunction

  task automatic build_exp(input bit trip, input bit dec, input logic [63:0] ka, kb, kc);
    int npass;
    logic [63:0] key;
    bit pdec;
    int r;
    exp_t e;
    exp_q.delete();
    npass = trip ? 3 : 1;
    for (int p = 0; p < npass; p++) begin
      if (!trip)       key = ka;
      else if (p == 1) key = kb;
      else if (p == 0) key = dec ? kc : ka;
      else             key = dec ? ka : kc;
      pdec = trip ? (dec ? (p != 1) : (p == 1)) : dec;
      for (int k = 0; k < 16; k++) begin
        r     = pdec ? 15 - k : k;
        e.sk  = ref_subkey(key, r + 1);
        e.rnd = r;
        e.pas = p;
        e.lst = (p == npass - 1) && (k == 15);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_subkey"}, subkey, 0);
    check_eq({tag, "_valid"},  valid,  0);
    check_eq({tag, "_round"},  round,  0);
    check_eq({tag, "_pass"},   pass_w, 0);
    check_eq({tag, "_last"},   last,   0);
    check_eq({tag, "_busy"},   busy,   0);
    check_eq({tag, "_done"},   done,   0);
  endtask

  // stop_mode: 0 none, 1 abort, 2 reset at (stop_pass, stop_round)
  task automatic run_sched(input bit trip, input bit dec, input logic [63:0] ka, kb, kc,
                           input int stall_pct, input int stop_mode,
                           input int stop_pass, input int stop_round);
    int cyc;
    bit held;
    logic [47:0] h_sk;
    logic [3:0]  h_rnd;
    logic [1:0]  h_pas;
    logic        h_lst;
    int total;
    build_exp(trip, dec, ka, kb, kc);
    total = exp_q.size();
    sel = trip;
    key_a = ka; key_b = kb; key_c = kc; decrypt = dec;
    ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    held = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      check_eq("valid", valid, 1);
      check_eq("busy_run", busy, 1);
      check_eq("subkey", subkey, exp_q[0].sk);
      check_eq("round", round, exp_q[0].rnd);
      check_eq("pass", pass_w, exp_q[0].pas);
      check_eq("last", last, exp_q[0].lst);
      if (held) begin
        check_eq("hold_subkey", subkey, h_sk);
        check_eq("hold_round", round, h_rnd);
        check_eq("hold_pass", pass_w, h_pas);
        check_eq("hold_last", last, h_lst);
      end
      if (cyc == 0) begin
        first_sk = subkey;
        first_rnd = round;
      end
      if (stop_mode != 0 && exp_q[0].pas == stop_pass && exp_q[0].rnd == stop_round) begin
        start = 1'b0;
        if (stop_mode == 1) begin
          abort = 1'b1;
          ready = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          ready = 1'b0;
          check_eq("abort_valid", valid, 0);
          check_eq("abort_busy", busy, 0);
          check_eq("abort_done", done, 0);
          @(posedge clk); #1;
          check_eq("abort_done2", done, 0);
          check_eq("abort_busy2", busy, 0);
        end else begin
          #2 rst = 1'b1;
          #1 check_zero("rst_async");
          start = 1'b1;
          repeat (2) @(posedge clk);
          #1;
          check_zero("rst_held");
          rst = 1'b0;
          start = 1'b0;
          @(posedge clk); #1;
          check_eq("rst_after_busy", busy, 0);
        end
        return;
      end
      ready   = ($urandom_range(99) >= stall_pct);
      key_a   = {$urandom, $urandom};
      key_b   = {$urandom, $urandom};
      key_c   = {$urandom, $urandom};
      decrypt = $urandom_range(1);
      start   = $urandom_range(1);
      if (ready) begin
        last_sk  = subkey;
        last_rnd = round;
        void'(exp_q.pop_front());
        held = 0;
      end else begin
        held  = 1;
        h_sk  = subkey;
        h_rnd = round;
        h_pas = pass_w;
        h_lst = last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ready = 1'b0;
    if (exp_q.size() > 0) begin
      check_eq("timeout_remaining", exp_q.size(), 0);
      rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (stall_pct == 0) check_eq("cycles", cyc, total);
    check_eq("fin_done", done, 1);
    check_eq("fin_valid", valid, 0);
    check_eq("fin_busy", busy, 1);
    @(posedge clk); #1;
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; decrypt = 1'b0; ready = 1'b0; sel = 1'b0;
    key_a = '0; key_b = '0; key_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_s");
    sel = 1'b1;
    #1 check_zero("reset_t");
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer single DES, both directions
    run_sched(0, 0, KEY_REF, KEY_REF, KEY_REF, 0, 0, 0, 0);
    check_eq("kat_enc_first", first_sk, K1_REF);
    check_eq("kat_enc_first_rnd", first_rnd, 0);
    check_eq("kat_enc_last", last_sk, K16_REF);
    run_sched(0, 1, KEY_REF, KEY_REF, KEY_REF, 0, 0, 0, 0);
    check_eq("kat_dec_first", first_sk, K16_REF);
    check_eq("kat_dec_first_rnd", first_rnd, 15);
    check_eq("kat_dec_last", last_sk, K1_REF);
    check_eq("kat_dec_last_rnd", last_rnd, 0);

    // Triple with equal keys, full throughput
    run_sched(1, 0, KEY_REF, KEY_REF, KEY_REF, 0, 0, 0, 0);

    // Stalls
    run_sched(0, 0, KEY_REF, KEY_REF, KEY_REF, 50, 0, 0, 0);
    check_eq("stall_first", first_sk, K1_REF);
    check_eq("stall_last", last_sk, K16_REF);

    // Random keys, both widths and directions
    for (int i = 0; i < 4; i++) begin
      run_sched(1, i[0], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                (i < 2) ? 0 : 40, 0, 0, 0);
      run_sched(0, i[0], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                30, 0, 0, 0);
    end

    // Abort at K8, then a clean restart
    run_sched(0, 0, KEY_REF, KEY_REF, KEY_REF, 0, 1, 0, 7);
    run_sched(0, 0, KEY_REF, KEY_REF, KEY_REF, 0, 0, 0, 0);
    check_eq("post_abort_first", first_sk, K1_REF);

    // Reset inside the reversed middle pass, then a clean restart
    run_sched(1, 0, KEY_REF, KEY_REF, KEY_REF, 0, 2, 1, 10);
    run_sched(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 20, 0, 0, 0);

    // Abort together with start in idle: start must be dropped
    sel = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_start_busy", busy, 0);
    check_eq("abort_start_valid", valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter TRIPLE, default 1; 1 = three-key EDE sequencing (3 passes of 16 subkeys), 0 = single DES (1 pass).
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  request a new schedule; sampled only in IDLE.
REQ-005 ABORT  in  1  synchronous cancel of a running schedule.
REQ-006 DECRYPT  in  1  direction, latched on accepted START.
REQ-007 KEY_A, KEY_B, KEY_C  in  64 each  DES keys, latched on accepted START; bit 64 = DES bit 1; parity bits ignored.
REQ-008 SUBKEY  out  48  current round subkey; bit 48 = DES bit 1.
REQ-009 SUBKEY_VALID  out  1  SUBKEY is presented.
REQ-010 SUBKEY_READY  in  1  round engine consumes SUBKEY this cycle.
REQ-011 ROUND  out  4  DES key index of SUBKEY minus 1 (0 = K1 … 15 = K16).
REQ-012 PASS  out  2  current pass, 0..2.
REQ-013 LAST  out  1  SUBKEY is the final subkey of the final pass.
REQ-014 BUSY  out  1  high in any state except IDLE.
REQ-015 DONE  out  1  one-cycle pulse after the final transfer.

Function
REQ-016 States: IDLE, RUN, FIN. IDLE→RUN on START; RUN→FIN on transfer with LAST; FIN→IDLE unconditionally (DONE=1 in FIN only).
REQ-017 Transfer = SUBKEY_VALID & SUBKEY_READY; SUBKEY_VALID = 1 exactly in RUN.
REQ-018 SUBKEY, ROUND, PASS, LAST SHALL hold stable while SUBKEY_VALID & !SUBKEY_READY.
REQ-019 Latency: START accepted in cycle N → first SUBKEY_VALID in cycle N+1.
REQ-020 Halves C,D (28 b each) are loaded from PC1 of the pass key; SUBKEY = PC2(C,D) combinationally from registers.
REQ-021 Shift schedule s[i] = 1 for i ∈ {1,2,9,16}, else 2.
REQ-022 Encrypt pass: load C,D = rotl(PC1, 1) (K1 ready); on transfer of Ki, C,D ← rotl(C,D, s[i+1]); ROUND counts 0→15.
REQ-023 Decrypt pass: load C,D = PC1 (equals C16,D16, K16 ready); on transfer of Ki, C,D ← rotr(C,D, s[i]); ROUND counts 15→0.
REQ-024 TRIPLE=1, DECRYPT=0: passes use (KEY_A enc, KEY_B dec, KEY_C enc); DECRYPT=1: (KEY_C dec, KEY_B enc, KEY_A dec).
REQ-025 TRIPLE=0: single pass, KEY_A, direction DECRYPT; KEY_B/KEY_C ignored; PASS stays 0.
REQ-026 Pass boundary: the transfer of the 16th subkey of pass p loads the next pass key; first subkey of pass p+1 is valid the following cycle (no bubble).
REQ-027 START while BUSY SHALL be ignored; key/direction inputs changing while BUSY SHALL have no effect.
REQ-028 ABORT in RUN → IDLE next cycle, no DONE, SUBKEY_VALID low next cycle; ABORT in IDLE or FIN no effect; ABORT with START in IDLE: START ignored.
REQ-029 ABORT coincident with a transfer: transfer counts for the consumer, schedule still aborted.

Reset
REQ-030 RESET SHALL asynchronously force IDLE; SUBKEY=0, SUBKEY_VALID=0, ROUND=0, PASS=0, LAST=0, BUSY=0, DONE=0; latched keys and C,D cleared.
REQ-031 Reset mid-schedule SHALL discard the schedule; first START after deassertion behaves as from power-up.

Structure
REQ-032 Shared package holds PC1 and PC2 tables, shift schedule s[1..16], state enumeration, and widths (key 64, half 28, subkey 48).
REQ-033 One sub-module, pc2_perm (56→48 combinational permutation); PC1, rotation, counters and FSM in key_sched_ctrl.

Verification
REQ-034 TRIPLE=0, KEY_A=133457799BBCDFF1, DECRYPT=0, READY=1 → K1=1B02EFFC7072 one cycle after START, K16=CB3D8B0E17F5 15 cycles later, LAST with K16, DONE next cycle.
REQ-035 Same key, DECRYPT=1 → first SUBKEY=CB3D8B0E17F5 (ROUND=15), last SUBKEY=1B02EFFC7072 (ROUND=0).
REQ-036 TRIPLE=1, KEY_A=KEY_B=KEY_C=133457799BBCDFF1, DECRYPT=0 → 48 transfers in 48 cycles; pass 1 runs reversed; PASS 0→1→2; no bubble at boundaries.
REQ-037 READY random 50% stall → SUBKEY sequence identical to REQ-034, outputs stable during every stall.
REQ-038 ABORT at ROUND=7 → SUBKEY_VALID low next cycle, BUSY low, no DONE; new START then yields K1 correctly.
REQ-039 RESET pulse at ROUND=10 of pass 1 → all outputs zero immediately; START ignored while RESET high.
